seq_addsub: RTL and testbench
=============================

SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits; SHALL be a positive multiple of CHUNK.
REQ-002 Parameter CHUNK, 8, bits processed per clock cycle; N = WIDTH/CHUNK chunk steps per operation.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a new operation; sampled only when accepted (REQ-012).
REQ-006 sub  input  1  mode: 0 = a + b + cin, 1 = a - b.
REQ-007 a  input  WIDTH  first operand, sampled on accepted start.
REQ-008 b  input  WIDTH  second operand, sampled on accepted start.
REQ-009 cin  input  1  carry-in for add mode, sampled on accepted start; ignored when sub=1.
REQ-010 s  output  WIDTH  registered result, held until the next completion.
REQ-011 cout, ovf, busy, done  output  1 each  carry-out (sub: 1 = no borrow), signed overflow, operation in progress, one-cycle completion pulse.

Function
REQ-012 FSM states IDLE, RUN, DONE; start SHALL be accepted in IDLE or DONE, and ignored in RUN.
REQ-013 On accepted start: latch a, b_eff = sub ? ~b : b, carry = sub ? 1 : cin, step counter = 0, go to RUN.
REQ-014 In RUN, each cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of a and b_eff plus the carry register, store the CHUNK-bit sum in the working register, and update the carry register with the chunk carry-out; LSB chunk first.
REQ-015 After step N-1, state SHALL go to DONE; s, cout, ovf SHALL load from the working result in the same edge.
REQ-016 Latency: start accepted at edge T SHALL give done=1 and valid s/cout/ovf during the cycle following edge T+N.
REQ-017 done SHALL be high only in DONE, exactly one cycle per operation; busy SHALL be high only in RUN.
REQ-018 DONE SHALL return to IDLE next edge unless start=1, which SHALL accept a new operation (back-to-back, no idle bubble).
REQ-019 ovf SHALL equal carry into MSB XOR carry out of MSB of the full WIDTH-bit sum.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL be bit WIDTH of the unsigned sum a + b_eff + carry.
REQ-021 Inputs a, b, sub, cin changing during RUN SHALL NOT affect the operation in progress.
REQ-022 s, cout, ovf SHALL hold their last completed values in IDLE and RUN until the next completion.
REQ-023 When N = 1, the block SHALL complete in a single RUN cycle with identical behaviour.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, s=0, cout=0, ovf=0, busy=0, done=0, counter, carry and working register to 0, regardless of clk.
REQ-025 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-026 After rst_n release, the first start SHALL be accepted on the first rising edge with rst_n=1.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-027 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> s=0x00000000, cout=1, ovf=0, done 4 cycles after accept.
REQ-028 a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> s=0x80000000, cout=0, ovf=1.
REQ-029 a=0x00000005, b=0x00000007, sub=1 -> s=0xFFFFFFFE, cout=0, ovf=0; a=0x80000000, b=1, sub=1 -> s=0x7FFFFFFF, ovf=1, cout=1.
REQ-030 start pulsed with a=1, b=1 while busy (a=2,b=2 in flight) -> ignored; result s=0x00000004, single done pulse.
REQ-031 rst_n low at RUN step 2 -> all outputs 0 within the same cycle, busy=0, no done after release.
REQ-032 start held high in DONE with a=0x10, b=0x20 -> new operation accepted, busy next cycle, s=0x00000030 after 4 further cycles; prior s held meanwhile.

Source files
------------

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// and publishes a registered sum, carry-out and signed overflow on completion.
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, work, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] a_chk, b_chk, csum;
  logic             cco, msb_cin, accept, last;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  always_comb begin
    a_chk           = a_reg[cnt*CHUNK +: CHUNK];
    b_chk           = b_reg[cnt*CHUNK +: CHUNK];
    {cco, csum}     = chunk_add(a_chk, b_chk, carry);
    // carry into the top bit is recoverable from the operand and sum bits
    msb_cin         = a_chk[CHUNK-1] ^ b_chk[CHUNK-1] ^ csum[CHUNK-1];
    res             = work;
    res[cnt*CHUNK +: CHUNK] = csum;
    last            = (cnt == CW'(N - 1));
    accept          = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      work  <= res;
      carry <= cco;
      cnt   <= cnt + CW'(1);
      if (last) begin
        s    <= res;
        cout <= cco;
        ovf  <= msb_cin ^ cco;
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed and randomized bench for seq_addsub against a whole-word arithmetic model.
module tb_seq_addsub;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, sub, cin;
  logic [W-1:0] a, b, s;
  logic         cout, ovf, busy, done;

  int total = 0;
  int passed = 0;

  logic [W-1:0] hs, es;
  logic         hc, ho, ec, eo;

  seq_addsub #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .cin(cin), .s(s), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Whole-word reference: {ovf, cout, s}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic m, input logic ci);
    logic [W:0]   u;
    logic         o;
    if (m) u = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   u = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    if (m) o = (x[W-1] != y[W-1]) && (u[W-1] != x[W-1]);
    else   o = (x[W-1] == y[W-1]) && (u[W-1] != x[W-1]);
    return {o, u};
  endfunction

  // Called at a negedge; the following rising edge accepts the operation.
  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic icin);
    a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
    {eo, ec, es} = model(ia, ib, isub, icin);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
  endtask

  task automatic finish_op(input string tag);
    for (int k = 0; k < N; k++) begin
      chk({tag, "_busy"}, W'(busy), W'(1));
      chk({tag, "_nodone"}, W'(done), W'(0));
      chk({tag, "_hold_s"}, s, hs);
      if (k == 0) begin
        chk({tag, "_hold_c"}, W'(cout), W'(hc));
        chk({tag, "_hold_o"}, W'(ovf), W'(ho));
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk({tag, "_done"}, W'(done), W'(1));
    chk({tag, "_idlebusy"}, W'(busy), W'(0));
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, W'(cout), W'(ec));
    chk({tag, "_ovf"}, W'(ovf), W'(eo));
    hs = es; hc = ec; ho = eo;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_pulse"}, W'(done), W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_s"}, s, hs);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    hs = '0; hc = 1'b0; ho = 1'b0;
    #3;
    chk("rst_s", s, '0);
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));

    // first start right after release
    @(negedge clk);
    rst_n = 1'b1;
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    finish_op("wrap");
    chk("wrap_s_const", s, 32'h0000_0000);

    // back-to-back from DONE
    launch(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    finish_op("b2b");
    chk("b2b_s_const", s, 32'h0000_0030);
    idle_check("b2b_idle");

    launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    finish_op("povf");
    chk("povf_s_const", s, 32'h8000_0000);
    chk("povf_ovf_const", W'(ovf), W'(1));
    idle_check("povf_idle");

    launch(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    finish_op("sub_neg");
    chk("sub_neg_s_const", s, 32'hFFFF_FFFE);
    chk("sub_neg_cout_const", W'(cout), W'(0));
    idle_check("sub_neg_idle");

    launch(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    finish_op("sub_ovf");
    chk("sub_ovf_s_const", s, 32'h7FFF_FFFF);
    chk("sub_ovf_flags", W'({cout, ovf}), W'(2'b11));
    idle_check("sub_ovf_idle");

    // start during RUN is ignored
    launch(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0);
    start = 1'b1; a = 32'h1; b = 32'h1;
    finish_op("ignore");
    chk("ignore_s_const", s, 32'h0000_0004);
    idle_check("ignore_idle");

    for (int i = 0; i < 24; i++) begin
      launch($urandom, $urandom, 1'($urandom), 1'($urandom));
      finish_op("rand");
      if (($urandom % 2) == 0) idle_check("rand_idle");
    end

    // abort mid-operation with asynchronous reset
    launch($urandom, $urandom, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_s", s, '0);
    chk("abort_cout", W'(cout), W'(0));
    chk("abort_ovf", W'(ovf), W'(0));
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    hs = '0; hc = 1'b0; ho = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_hold_done", W'(done), W'(0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      chk("abort_nodone", W'(done), W'(0));
      chk("abort_nobusy", W'(busy), W'(0));
    end
    launch(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    finish_op("post_rst");
    idle_check("post_rst_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
